// File: rtl/apb4_master.sv
// apb4_master: single-outstanding APB4 master bridging a valid/ready command
// port to an APB4 bus and returning one response per command.
// Optional feature macro: APB4_MASTER_TIMEOUT_EN (access-phase timeout abort).
//
// Handshake rule for both ports: a transfer happens on a rising clk edge where
// valid and ready are both high; valid never depends combinationally on ready.
module apb4_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic [1:0]              dbg_state
);

  localparam int SW = DATA_WIDTH / 8;

  // Reject parameter values the bus protocol or the 16-bit counter cannot honour.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64) ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("apb4_master: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, next_state;

  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         strb_q;
  logic [2:0]            prot_q;
  logic                  xfer_done;
  logic                  bus_on;
  logic                  wr_on;

`ifdef APB4_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
  logic        xfer_abort;
  logic        timeout_q;
`endif

  assign dbg_state = state;

  // State register; reset drops any transfer in flight without a response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    rsp_valid  = 1'b0;
    xfer_done  = 1'b0;
`ifdef APB4_MASTER_TIMEOUT_EN
    xfer_abort = 1'b0;
`endif
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = SETUP;
      end
      SETUP: begin
        psel       = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          xfer_done  = 1'b1;
          next_state = RESP;
        end
`ifdef APB4_MASTER_TIMEOUT_EN
        // Counter holds the number of stalled cycles before this one.
        else if (wait_cnt == TIMEOUT_LAST) begin
          xfer_abort = 1'b1;
          next_state = RESP;
        end
`endif
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture the command on the IDLE handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else if (cmd_valid && cmd_ready) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      strb_q  <= cmd_strb;
      prot_q  <= cmd_prot;
    end
  end

  // APB buses are live only while psel is high; reads drive no data or strobes.
  assign bus_on = psel;
  assign wr_on  = bus_on & write_q;
  assign pwrite = wr_on;
  assign paddr  = bus_on ? addr_q  : '0;
  assign pprot  = bus_on ? prot_q  : '0;
  assign pwdata = wr_on  ? wdata_q : '0;
  assign pstrb  = wr_on  ? strb_q  : '0;

  // Response capture; prdata/pslverr are only looked at when pready completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (xfer_done) begin
      rsp_rdata <= write_q ? '0 : prdata;
      rsp_err   <= pslverr;
    end
`ifdef APB4_MASTER_TIMEOUT_EN
    else if (xfer_abort) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
`endif
  end

`ifdef APB4_MASTER_TIMEOUT_EN
  // Stall counter: cleared on the way into ACCESS, counts cycles without pready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         wait_cnt <= '0;
    else if (state == SETUP)              wait_cnt <= '0;
    else if (state == ACCESS && !pready)  wait_cnt <= wait_cnt + 16'd1;
  end

  // Timeout flag travels with the rest of the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        timeout_q <= 1'b0;
    else if (xfer_done)  timeout_q <= 1'b0;
    else if (xfer_abort) timeout_q <= 1'b1;
  end

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_master.sv
// tb_apb4_master: directed bench for apb4_master with a response scoreboard.
// Define APB4_MASTER_TIMEOUT_EN to also exercise the timeout abort path.
`timescale 1ns/1ps
module tb_apb4_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int RW = DW + 2;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic [1:0]    dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected responses: {timeout, err, rdata}
  logic [RW-1:0] exp_q[$];

  apb4_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .cmd_prot   (cmd_prot),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake pops and checks one scoreboard entry.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got 0x%0h expected no response",
                 {rsp_timeout, rsp_err, rsp_rdata});
      end else begin
        chk("rsp_fields", 64'({rsp_timeout, rsp_err, rsp_rdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Driver: one command plus cycle-by-cycle slave behaviour. Called and
  // returns just after a rising edge with the DUT in IDLE.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                          input logic [2:0] prot, input int waits,
                          input logic [DW-1:0] rdata, input logic err,
                          input logic junk_err, input int hold);
    logic [RW-1:0] exp;
    exp = {1'b0, err, (wr ? {DW{1'b0}} : rdata)};
    exp_q.push_back(exp);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    rsp_ready = (hold == 0);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("setup_psel_penable", {psel, penable}, 2'b10);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pstrb", pstrb, wr ? strb : '0);
    chk("setup_pwdata", pwdata, wr ? wdata : '0);
    chk("setup_pprot", pprot, prot);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      chk("access_psel_penable", {psel, penable}, 2'b11);
      chk("access_paddr", paddr, addr);
      chk("access_pstrb", pstrb, wr ? strb : '0);
      chk("access_rsp_valid", rsp_valid, 0);
      pready  = (i == waits);
      pslverr = (i == waits) ? err : junk_err;
      prdata  = (i == waits) ? rdata : (32'hBAD0_0000 + i);
    end
    @(posedge clk); #1;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h5555_5555;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_bus_idle", 64'({psel, penable, pwrite, paddr, pstrb, pprot}), 0);
    chk("resp_pwdata", pwdata, 0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_fields", 64'({rsp_timeout, rsp_err, rsp_rdata}), 64'(exp));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b1;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    #23;
    chk("reset_outputs", 64'({psel, penable, pwrite, paddr, pstrb, pprot, rsp_valid,
                              rsp_err, rsp_timeout}), 0);
    chk("reset_rdata", rsp_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Zero-wait write
    apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0, 1'b0, 0);
    // Read with three wait states, nonzero wdata/strb must not reach the bus
    apb_xfer(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'd2, 3, 32'h1234_5678, 1'b0, 1'b0, 0);
    // Write with slave error at completion, error pulses during stalls too
    apb_xfer(1'b1, 32'h30, 32'h0BAD_F00D, 4'h3, 3'd5, 2, 32'h0, 1'b1, 1'b1, 0);
    // Read where the error pulse during a stall must be ignored
    apb_xfer(1'b0, 32'h34, 32'h0, 4'h0, 3'd7, 1, 32'hA5A5_5A5A, 1'b0, 1'b1, 0);
    // Response back-pressure for 5 cycles, then an immediate next command
    apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'd1, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 5);
    apb_xfer(1'b1, 32'h44, 32'h1357_9BDF, 4'hC, 3'd4, 0, 32'h0, 1'b0, 1'b0, 0);
    // Read leaving nonzero rsp_rdata, so reset must visibly clear it
    apb_xfer(1'b0, 32'h48, 32'h0, 4'h0, 3'd0, 0, 32'h8765_4321, 1'b0, 1'b0, 0);

    // Reset in the middle of ACCESS
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'hABC0;
    cmd_wdata = 32'hFEED_FACE;
    cmd_strb  = 4'hF;
    cmd_prot  = 3'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_penable", penable, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_bus", 64'({psel, penable, pwrite, paddr, pstrb, pprot}), 0);
    chk("rst_async_pwdata", pwdata, 0);
    chk("rst_async_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_release_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    chk("rst_no_response", rsp_valid, 0);

    // Recovery after reset
    apb_xfer(1'b1, 32'h50, 32'h0102_0304, 4'h1, 3'd6, 1, 32'h0, 1'b0, 1'b0, 0);

`ifdef APB4_MASTER_TIMEOUT_EN
    // Slave never ready: abort after four ACCESS cycles
    exp_q.push_back({1'b1, 1'b1, {DW{1'b0}}});
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h60;
    cmd_strb  = 4'h0;
    cmd_prot  = 3'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pready    = 1'b0;
    prdata    = 32'hDDDD_DDDD;
    n = 0;
    @(posedge clk); #1;
    while (penable && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_access_cycles", n, 4);
    chk("timeout_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    apb_xfer(1'b0, 32'h64, 32'h0, 4'h0, 3'd0, 2, 32'h7777_0001, 1'b0, 1'b0, 0);
`endif

    n = 0;
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
